gadget_scale: RTL
=================

GADGET_SCALE -- requirements
Module: gadget_scale

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the message, gadget-power and product words.
- REQ-002 SHALL have parameter n_WIDTH, default 8: width of the internal bit counter; n_WIDTH SHALL satisfy 2^n_WIDTH > DATA_WIDTH.
- REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
- REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (rst=0 resets, rst=1 runs).
- REQ-005 SHALL have port start, input, 1 bit: request to scale one message coefficient.
- REQ-006 SHALL have port Mu, input, signed DATA_WIDTH bits: message coefficient (torus32 / integer).
- REQ-007 SHALL have ports GPow0, GPow1, GPow2, each input, signed DATA_WIDTH bits: gadget powers from the upstream precompute stage.
- REQ-008 SHALL have port GOut, output, signed DATA_WIDTH bits: current product Mu*GPow[idx].
- REQ-009 SHALL have port idx, output, 2 bits: gadget level (0..2) of GOut.
- REQ-010 SHALL have port valid, output, 1 bit: GOut/idx are valid this cycle.
- REQ-011 SHALL have port ready, output, 1 bit: block idle; start is accepted.
- REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when all three products are emitted.

Function
- REQ-013 SHALL implement states IDLE, MUL, EMIT, DONE.
- REQ-014 SHALL, in IDLE, drive ready=1; all other outputs SHALL hold their prior values except valid=0 and done=0.
- REQ-015 SHALL accept start only when sampled high in IDLE at a rising edge; it SHALL then latch Mu, GPow0, GPow1 and GPow2, clear the accumulator and bit counter, set idx=0, and enter MUL.
- REQ-016 SHALL ignore start in every state other than IDLE; latched operands SHALL NOT change while busy, even if the inputs change.
- REQ-017 SHALL, in MUL, perform one shift-add step per cycle: if bit k of latched Mu is 1, add (GPow[idx] << k) to the accumulator, then increment k.
- REQ-018 SHALL leave MUL for EMIT after exactly DATA_WIDTH MUL cycles, including when Mu=0; early termination is not permitted.
- REQ-019 SHALL compute the product modulo 2^DATA_WIDTH, i.e. the low DATA_WIDTH bits of the two's-complement product; overflow SHALL wrap silently.
- REQ-020 SHALL, in EMIT, drive valid=1 for exactly one cycle, with GOut equal to the accumulator and idx equal to the current level.
- REQ-021 SHALL, after EMIT with idx<2, increment idx, clear the accumulator and counter, and return to MUL.
- REQ-022 SHALL, after EMIT with idx=2, enter DONE.
- REQ-023 SHALL, in DONE, drive done=1 for one cycle and then return to IDLE.
- REQ-024 SHALL assert ready again in the cycle after the done pulse.
- REQ-025 SHALL meet this latency: the first valid occurs DATA_WIDTH+1 edges after the accepting edge; consecutive valids are DATA_WIDTH+1 cycles apart; done follows the third valid by one cycle.
- REQ-026 SHALL hold GOut and idx stable after EMIT until the next EMIT, and SHALL NOT deassert them on return to IDLE.

Reset
- REQ-027 SHALL, while rst=0, force state=IDLE, GOut=0, idx=0, valid=0, done=0, ready=1, and clear the accumulator, counter and latched operands.
- REQ-028 SHALL, on reset asserted mid-operation, abort immediately, emit no further valid or done pulse, and accept a new start after rst returns to 1.

Verification
- REQ-029 SHALL verify: Mu=1, GPow0/1/2 = 0x40000000/0x00200000/0x00000400 -> valid×3 with idx 0,1,2 and GOut equal to the three GPow values; first valid 33 edges after start; done one cycle after the third valid.
- REQ-030 SHALL verify: Mu=-1 (0xFFFFFFFF), same GPow -> GOut 0xC0000000, 0xFFE00000, 0xFFFFFC00.
- REQ-031 SHALL verify wrap: Mu=3, GPow0=0x40000000 -> GOut 0xC0000000 at idx 0, with no error flag.
- REQ-032 SHALL verify: Mu=0 -> three zero products, with the full 33-cycle spacing preserved.
- REQ-033 SHALL verify: start re-pulsed and Mu/GPow inputs changed during MUL -> results match the originally latched operands, and no second run occurs.
- REQ-034 SHALL verify: rst driven low during idx=1 MUL -> outputs at reset values, no done pulse; a following start runs normally to completion.

Source files
------------

// File: rtl/gadget_scale.sv
// Sequential gadget scaler: multiplies one message coefficient by three gadget
// powers with a bit-serial shift-add, emitting each product mod 2^DATA_WIDTH.
module gadget_scale #(
    parameter int DATA_WIDTH = 32,
    parameter int n_WIDTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] Mu,
    input  logic signed [DATA_WIDTH-1:0] GPow0,
    input  logic signed [DATA_WIDTH-1:0] GPow1,
    input  logic signed [DATA_WIDTH-1:0] GPow2,
    output logic signed [DATA_WIDTH-1:0] GOut,
    output logic [1:0]                   idx,
    output logic                         valid,
    output logic                         ready,
    output logic                         done
);

    typedef enum logic [1:0] {IDLE, MUL, EMIT, DONE} state_t;

    state_t                      state_q, state_d;
    logic [DATA_WIDTH-1:0]       mu_q, mu_d;
    logic [2:0][DATA_WIDTH-1:0]  gp_q, gp_d;
    logic [DATA_WIDTH-1:0]       acc_q, acc_d;
    logic [n_WIDTH-1:0]          k_q, k_d;
    logic [1:0]                  lvl_q, lvl_d;
    logic [DATA_WIDTH-1:0]       gout_q, gout_d;
    logic [1:0]                  idx_q, idx_d;
    logic                        valid_q, valid_d;
    logic                        done_q, done_d;
    logic                        ready_q, ready_d;
    logic [DATA_WIDTH-1:0]       gsel;
    logic                        mu_bit;

    always_comb begin
        state_d = state_q;
        mu_d    = mu_q;
        gp_d    = gp_q;
        acc_d   = acc_q;
        k_d     = k_q;
        lvl_d   = lvl_q;
        gout_d  = gout_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        ready_d = ready_q;

        case (lvl_q)
            2'd0:    gsel = gp_q[0];
            2'd1:    gsel = gp_q[1];
            default: gsel = gp_q[2];
        endcase
        mu_bit = |(mu_q & (DATA_WIDTH'(1) << k_q));

        case (state_q)
            IDLE: begin
                // ready stays low through the done cycle, so a start there is dropped
                if (start && ready_q) begin
                    mu_d    = Mu;
                    gp_d[0] = GPow0;
                    gp_d[1] = GPow1;
                    gp_d[2] = GPow2;
                    acc_d   = '0;
                    k_d     = '0;
                    lvl_d   = 2'd0;
                    ready_d = 1'b0;
                    state_d = MUL;
                end else begin
                    ready_d = 1'b1;
                end
            end
            MUL: begin
                if (mu_bit)
                    acc_d = acc_q + (gsel << k_q);
                k_d = k_q + 1'b1;
                if (k_q == n_WIDTH'(DATA_WIDTH - 1))
                    state_d = EMIT;
            end
            EMIT: begin
                gout_d  = acc_q;
                idx_d   = lvl_q;
                valid_d = 1'b1;
                if (lvl_q == 2'd2) begin
                    state_d = DONE;
                end else begin
                    lvl_d   = lvl_q + 2'd1;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MUL;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mu_q    <= '0;
            gp_q    <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            lvl_q   <= '0;
            gout_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            mu_q    <= mu_d;
            gp_q    <= gp_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            lvl_q   <= lvl_d;
            gout_q  <= gout_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign GOut  = gout_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign done  = done_q;
    assign ready = ready_q;

endmodule
